// File: rtl/mwb_access_unit.sv
// mwb_access_unit: memory / write-back stage of the three-stage RISC-V pipeline.
// Issues loads and stores over a req/ack data port, stalls the front of the
// pipeline while an access is outstanding, and produces a one-cycle register
// file write. Misaligned accesses are dropped and slow accesses are aborted.
module mwb_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] IMME_result_in,
    input  logic [31:0] PC_in,
    input  logic [31:0] store_data_in,
    input  logic        Reg_WE_in,
    input  logic [1:0]  DMEM_sel_in,
    input  logic [2:0]  LOAD_sel_in,
    input  logic [1:0]  WB_sel_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Access attributes captured at issue so the write-back does not depend
    // on the stalled upstream register staying put.
    logic       ld_is_load;
    logic [1:0] ld_lane;
    logic [1:0] ld_size;
    logic       ld_unsigned;
    logic [4:0] ld_rd;
    logic       ld_we;

    logic [4:0]  rd_field;
    logic        is_load;
    logic        is_store;
    logic        is_access;
    logic [1:0]  acc_size;
    logic        aligned;
    logic        mem_op;
    logic        rd_we_next;
    logic [3:0]  store_strb;
    logic [31:0] store_word;
    logic [31:0] wb_value;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic        unused_instr_bits;

    assign rd_field   = instruction_in[11:7];
    assign is_load    = (DMEM_sel_in == 2'b01);
    assign is_store   = (DMEM_sel_in == 2'b10);
    assign is_access  = is_load | is_store;
    assign acc_size   = LOAD_sel_in[1:0];
    assign mem_op     = is_access & aligned;
    assign rd_we_next = Reg_WE_in & (rd_field != 5'd0);
    assign unused_instr_bits = ^{instruction_in[31:12], instruction_in[6:0]};

    // Front of the pipeline holds while a request is being launched or is outstanding.
    assign stall = ~rst & ((state == S_WAIT) | ((state == S_IDLE) & mem_op));

    // Size-dependent alignment check, byte strobes and lane-replicated store data.
    always_comb begin
        aligned    = 1'b1;
        store_strb = 4'b1111;
        store_word = store_data_in;
        case (acc_size)
            2'b00: begin
                aligned    = 1'b1;
                store_strb = 4'b0001 << ALU_result_in[1:0];
                store_word = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                aligned    = ~ALU_result_in[0];
                store_strb = 4'b0011 << ALU_result_in[1:0];
                store_word = {2{store_data_in[15:0]}};
            end
            default: begin
                aligned    = (ALU_result_in[1:0] == 2'b00);
                store_strb = 4'b1111;
                store_word = store_data_in;
            end
        endcase
    end

    // Write-back source for instructions that do not touch memory.
    always_comb begin
        wb_value = 32'd0;
        case (WB_sel_in)
            2'b00:   wb_value = ALU_result_in;
            2'b01:   wb_value = 32'd0;
            2'b10:   wb_value = PC_in + 32'd4;
            default: wb_value = IMME_result_in;
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        load_byte  = 8'd0;
        load_half  = ld_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_value = mem_rdata;
        case (ld_lane)
            2'b00:   load_byte = mem_rdata[7:0];
            2'b01:   load_byte = mem_rdata[15:8];
            2'b10:   load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        case (ld_size)
            2'b00:   load_value = ld_unsigned ? {24'd0, load_byte}
                                              : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_value = ld_unsigned ? {16'd0, load_half}
                                              : {{16{load_half[15]}}, load_half};
            default: load_value = mem_rdata;
        endcase
    end

    // Access FSM with registered memory-port and write-back outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 30'd0;
            mem_wdata   <= 32'd0;
            mem_wstrb   <= 4'd0;
            rd_we       <= 1'b0;
            rd_addr     <= 5'd0;
            rd_data     <= 32'd0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            ld_is_load  <= 1'b0;
            ld_lane     <= 2'd0;
            ld_size     <= 2'd0;
            ld_unsigned <= 1'b0;
            ld_rd       <= 5'd0;
            ld_we       <= 1'b0;
        end else begin
            rd_we    <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        state       <= S_WAIT;
                        wait_cnt    <= '0;
                        mem_req     <= 1'b1;
                        mem_we      <= is_store;
                        mem_addr    <= ALU_result_in[31:2];
                        mem_wdata   <= is_store ? store_word : 32'd0;
                        mem_wstrb   <= is_store ? store_strb : 4'd0;
                        ld_is_load  <= is_load;
                        ld_lane     <= ALU_result_in[1:0];
                        ld_size     <= acc_size;
                        ld_unsigned <= LOAD_sel_in[2];
                        ld_rd       <= rd_field;
                        ld_we       <= rd_we_next;
                    end else if (is_access) begin
                        misalign <= 1'b1;
                    end else begin
                        rd_we   <= rd_we_next;
                        rd_addr <= rd_field;
                        rd_data <= wb_value;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                        if (ld_is_load) begin
                            rd_we   <= ld_we;
                            rd_addr <= ld_rd;
                            rd_data <= load_value;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mwb_access_unit.sv
// tb_mwb_access_unit: directed self-checking bench for mwb_access_unit.
// Each step drives one pipeline-register image and compares the DUT outputs
// against hand-computed values cycle by cycle.
module tb_mwb_access_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instruction_in;
    logic [31:0] ALU_result_in;
    logic [31:0] IMME_result_in;
    logic [31:0] PC_in;
    logic [31:0] store_data_in;
    logic        Reg_WE_in;
    logic [1:0]  DMEM_sel_in;
    logic [2:0]  LOAD_sel_in;
    logic [1:0]  WB_sel_in;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        misalign;
    logic        bus_err;

    int checks;
    int errors;
    int req_cycles;
    logic saw_bus_err;

    mwb_access_unit #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .instruction_in (instruction_in),
        .ALU_result_in  (ALU_result_in),
        .IMME_result_in (IMME_result_in),
        .PC_in          (PC_in),
        .store_data_in  (store_data_in),
        .Reg_WE_in      (Reg_WE_in),
        .DMEM_sel_in    (DMEM_sel_in),
        .LOAD_sel_in    (LOAD_sel_in),
        .WB_sel_in      (WB_sel_in),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .stall          (stall),
        .rd_we          (rd_we),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .misalign       (misalign),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] alu,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [31:0] sdata, input logic we,
                                 input logic [1:0] dmem, input logic [2:0] lsel,
                                 input logic [1:0] wbsel);
        instruction_in = instr;
        ALU_result_in  = alu;
        IMME_result_in = imm;
        PC_in          = pc;
        store_data_in  = sdata;
        Reg_WE_in      = we;
        DMEM_sel_in    = dmem;
        LOAD_sel_in    = lsel;
        WB_sel_in      = wbsel;
    endtask

    task automatic applyNop();
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 3'b000, 2'b00);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        applyNop();
        tick();
        tick();

        // Reset values
        checkOutput("rst_mem_req",   mem_req,   32'h0);
        checkOutput("rst_mem_we",    mem_we,    32'h0);
        checkOutput("rst_mem_addr",  mem_addr,  32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_mem_wstrb", mem_wstrb, 32'h0);
        checkOutput("rst_stall",     stall,     32'h0);
        checkOutput("rst_rd_we",     rd_we,     32'h0);
        checkOutput("rst_rd_addr",   rd_addr,   32'h0);
        checkOutput("rst_rd_data",   rd_data,   32'h0);
        checkOutput("rst_misalign",  misalign,  32'h0);
        checkOutput("rst_bus_err",   bus_err,   32'h0);
        rst = 1'b0;

        // ADDI x5 -> ALU result, one cycle to write-back
        applyStimulus(32'h00000293, 32'h00000123, 32'h0, 32'h100, 32'h0, 1'b1, 2'b00, 3'b000, 2'b00);
        #1 checkOutput("addi_stall_c0", stall, 32'h0);
        tick();
        checkOutput("addi_rd_we",   rd_we,   32'h1);
        checkOutput("addi_rd_addr", rd_addr, 32'h5);
        checkOutput("addi_rd_data", rd_data, 32'h00000123);
        checkOutput("addi_stall_c1", stall,  32'h0);

        // LUI x2 -> immediate
        applyStimulus(32'h00000137, 32'h0000DEAD, 32'h12345000, 32'h104, 32'h0, 1'b1, 2'b00, 3'b000, 2'b11);
        #1 checkOutput("lui_stall", stall, 32'h0);
        tick();
        checkOutput("lui_rd_we",   rd_we,   32'h1);
        checkOutput("lui_rd_addr", rd_addr, 32'h2);
        checkOutput("lui_rd_data", rd_data, 32'h12345000);

        // Write to x0 is suppressed
        applyStimulus(32'h00000013, 32'h00000055, 32'h0, 32'h108, 32'h0, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        checkOutput("x0_rd_we", rd_we, 32'h0);

        // DMEM_sel 11 is not an access; WB_sel 01 outside a load writes 0
        applyStimulus(32'h00000213, 32'h00000077, 32'h0, 32'h10C, 32'h1111, 1'b1, 2'b11, 3'b010, 2'b01);
        #1 checkOutput("sel11_stall", stall, 32'h0);
        tick();
        checkOutput("sel11_rd_we",   rd_we,   32'h1);
        checkOutput("sel11_rd_data", rd_data, 32'h0);
        checkOutput("sel11_mem_req", mem_req, 32'h0);

        // LB x7 from 0x1003, ack in cycle 3
        applyStimulus(32'h00000383, 32'h00001003, 32'h0, 32'h110, 32'h0, 1'b1, 2'b01, 3'b000, 2'b01);
        #1;
        checkOutput("lb_stall_c0",   stall,   32'h1);
        checkOutput("lb_mem_req_c0", mem_req, 32'h0);
        tick();
        checkOutput("lb_mem_req_c1",  mem_req,   32'h1);
        checkOutput("lb_mem_addr",    mem_addr,  32'h400);
        checkOutput("lb_mem_we",      mem_we,    32'h0);
        checkOutput("lb_mem_wstrb",   mem_wstrb, 32'h0);
        checkOutput("lb_stall_c1",    stall,     32'h1);
        checkOutput("lb_rd_we_c1",    rd_we,     32'h0);
        tick();
        checkOutput("lb_stall_c2",   stall,   32'h1);
        checkOutput("lb_mem_req_c2", mem_req, 32'h1);
        tick();
        checkOutput("lb_stall_c3", stall, 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h80FF0000;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        checkOutput("lb_mem_req_c4", mem_req, 32'h0);
        checkOutput("lb_stall_c4",   stall,   32'h0);
        checkOutput("lb_rd_we_c4",   rd_we,   32'h1);
        checkOutput("lb_rd_addr",    rd_addr, 32'h7);
        checkOutput("lb_rd_data",    rd_data, 32'hFFFFFF80);
        tick();
        applyNop();
        checkOutput("lb_rd_we_c5", rd_we, 32'h0);

        // SH at 0x2002, ack in cycle 1; register write enable deliberately set
        applyStimulus(32'h000011A3, 32'h00002002, 32'h0, 32'h114, 32'h0000ABCD, 1'b1, 2'b10, 3'b001, 2'b00);
        #1 checkOutput("sh_stall_c0", stall, 32'h1);
        tick();
        checkOutput("sh_mem_req",   mem_req,   32'h1);
        checkOutput("sh_mem_we",    mem_we,    32'h1);
        checkOutput("sh_mem_addr",  mem_addr,  32'h800);
        checkOutput("sh_mem_wstrb", mem_wstrb, 32'hC);
        checkOutput("sh_mem_wdata", mem_wdata, 32'hABCDABCD);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("sh_mem_req_c2", mem_req, 32'h0);
        checkOutput("sh_rd_we_c2",   rd_we,   32'h0);
        checkOutput("sh_stall_c2",   stall,   32'h0);
        tick();
        checkOutput("sh_rd_we_c3", rd_we, 32'h0);

        // LBU x12 from 0x1001, ack in cycle 1 (minimum stall)
        applyStimulus(32'h00004603, 32'h00001001, 32'h0, 32'h118, 32'h0, 1'b1, 2'b01, 3'b100, 2'b01);
        tick();
        checkOutput("lbu_mem_req", mem_req, 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h00009A00;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        checkOutput("lbu_rd_we",   rd_we,   32'h1);
        checkOutput("lbu_rd_addr", rd_addr, 32'hC);
        checkOutput("lbu_rd_data", rd_data, 32'h0000009A);
        checkOutput("lbu_stall",   stall,   32'h0);
        tick();

        // LW at 0x1001 is misaligned: dropped with a misalign pulse
        applyStimulus(32'h00002483, 32'h00001001, 32'h0, 32'h11C, 32'h0, 1'b1, 2'b01, 3'b010, 2'b01);
        #1 checkOutput("lw_mis_stall_c0", stall, 32'h0);
        tick();
        checkOutput("lw_mis_misalign", misalign, 32'h1);
        checkOutput("lw_mis_rd_we",    rd_we,    32'h0);
        checkOutput("lw_mis_mem_req",  mem_req,  32'h0);
        checkOutput("lw_mis_stall_c1", stall,    32'h0);
        applyNop();
        tick();
        checkOutput("lw_mis_pulse_end", misalign, 32'h0);

        // LHU x10 at 0x3002 never acknowledged: abort after 16 request cycles
        applyStimulus(32'h00005503, 32'h00003002, 32'h0, 32'h120, 32'h0, 1'b1, 2'b01, 3'b101, 2'b01);
        #1 checkOutput("lhu_stall_c0", stall, 32'h1);
        tick();
        req_cycles  = 0;
        saw_bus_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus_err) begin
                saw_bus_err = 1'b1;
                break;
            end
            if (!mem_req) break;
            req_cycles++;
            tick();
        end
        applyNop();
        checkOutput("to_bus_err_seen", saw_bus_err, 32'h1);
        checkOutput("to_req_cycles",   req_cycles,  32'd16);
        checkOutput("to_mem_req",      mem_req,     32'h0);
        checkOutput("to_rd_we",        rd_we,       32'h0);
        #1 checkOutput("to_stall", stall, 32'h0);
        tick();
        checkOutput("to_bus_err_end", bus_err, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        checkOutput("stray_ack_mem_req", mem_req, 32'h0);
        checkOutput("stray_ack_rd_we",   rd_we,   32'h0);
        checkOutput("stray_ack_stall",   stall,   32'h0);

        // JAL x1 at PC 0xFFFFFFFC: PC+4 wraps to 0
        applyStimulus(32'h000000EF, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 1'b1, 2'b00, 3'b000, 2'b10);
        tick();
        checkOutput("jal_rd_we",   rd_we,   32'h1);
        checkOutput("jal_rd_addr", rd_addr, 32'h1);
        checkOutput("jal_rd_data", rd_data, 32'h0);

        // LW x11 at 0x4000, reset while waiting
        applyStimulus(32'h00002583, 32'h00004000, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01, 3'b010, 2'b01);
        tick();
        checkOutput("rstw_mem_req_c1", mem_req, 32'h1);
        checkOutput("rstw_stall_c1",   stall,   32'h1);
        rst = 1'b1;
        tick();
        checkOutput("rstw_mem_req", mem_req, 32'h0);
        checkOutput("rstw_rd_we",   rd_we,   32'h0);
        checkOutput("rstw_bus_err", bus_err, 32'h0);
        applyNop();
        rst = 1'b0;
        tick();
        checkOutput("rstw_mem_req_after", mem_req, 32'h0);
        checkOutput("rstw_rd_we_after",   rd_we,   32'h0);
        checkOutput("rstw_bus_err_after", bus_err, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
